// File: rtl/fast_inv_sqrt_pipe.sv
// Purpose : pipelined fast inverse square root y ~= 1/sqrt(x) on unsigned Q(INT_WIDTH.FRACT_WIDTH)
//           operands (float bit-hack seed + NR_ITERS Newton-Raphson refinements).
// Latency : 3 + 2*NR_ITERS stage registers plus one output register; one result per cycle.
// Backpr. : ready_in = rst | !valid_out | ready_out; on a stall every stage register holds.
// Ports   : clk/rst (sync, active-high); data_in/valid_in/ready_in operand side;
//           data_out/valid_out/ready_out/zero_flag result side (zero_flag qualified by valid_out).
// Option  : define FAST_INV_SQRT_ROUND_EN for round-half-up on the NR-stage fixed-point shifts.
module fast_inv_sqrt_pipe #(
  parameter int          INT_WIDTH   = 12,
  parameter int          FRACT_WIDTH = 4,
  parameter int          NR_ITERS    = 1,
  parameter logic [31:0] MAGIC       = 32'h5f3759df,
  localparam int         WORD_WIDTH  = INT_WIDTH + FRACT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  zero_flag
);

  localparam int PW  = 2 * WORD_WIDTH;
  localparam int NST = 3 + 2 * NR_ITERS;

  localparam logic [PW-1:0] ONE_P5   = (PW'(3) << FRACT_WIDTH) >> 1;
  localparam logic [PW-1:0] WORD_MAX = (PW'(1) << WORD_WIDTH) - PW'(1);
`ifdef FAST_INV_SQRT_ROUND_EN
  localparam logic [PW-1:0] HALF_LSB =
      (FRACT_WIDTH == 0) ? '0 : (PW'(1) << ((FRACT_WIDTH == 0) ? 0 : FRACT_WIDTH - 1));
`endif

  // Fixed point to IEEE single; caller guarantees x != 0.
  function automatic logic [31:0] fix_to_float(input logic [WORD_WIDTH-1:0] x);
    int         p;
    logic [7:0] expo;
    logic [22:0] mant;
    p = 0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (x[i]) p = i;
    end
    expo = 8'(p - FRACT_WIDTH + 127);
    // Shifting the leading one out of a 32-bit window leaves the fraction bits at the top.
    mant = 23'((64'(x) << (32 - p)) >> 9);
    return {1'b0, expo, mant};
  endfunction

  // IEEE single (sign bit ignored) to fixed point, truncating, saturating high, flushing to 0 low.
  function automatic logic [WORD_WIDTH-1:0] float_to_fix(input logic [30:0] f);
    int          sh;
    logic [63:0] v;
    sh = int'(f[30:23]) - 150 + FRACT_WIDTH;
    v  = {40'b0, 1'b1, f[22:0]};
    if (sh + 23 >= WORD_WIDTH) return '1;
    if (sh >= 0)       v = v << sh;
    else if (sh < -23) v = '0;
    else               v = v >> (-sh);
    return WORD_WIDTH'(v);
  endfunction

  // The ">> FRACT_WIDTH" used after every NR product.
  function automatic logic [PW-1:0] shr_f(input logic [PW-1:0] v);
`ifdef FAST_INV_SQRT_ROUND_EN
    logic [PW:0]   s;
    logic [PW-1:0] r;
    s = {1'b0, v} + {1'b0, HALF_LSB};
    r = s[PW] ? '1 : s[PW-1:0];
    return r >> FRACT_WIDTH;
`else
    return v >> FRACT_WIDTH;
`endif
  endfunction

  // Stage 0 = F2S, 1 = HACK, 2 = S2F, then NRa/NRb pairs. pay holds the float or the fixed y;
  // aux carries u from NRa to NRb.
  logic                  vld_q  [NST];
  logic                  vld_d  [NST];
  logic                  zero_q [NST];
  logic                  zero_d [NST];
  logic [WORD_WIDTH-1:0] xh_q   [NST];
  logic [WORD_WIDTH-1:0] xh_d   [NST];
  logic [31:0]           pay_q  [NST];
  logic [31:0]           pay_d  [NST];
  logic [PW-1:0]         aux_q  [NST];
  logic [PW-1:0]         aux_d  [NST];

  logic                  vld_out_q,  vld_out_d;
  logic                  zero_out_q, zero_out_d;
  logic [WORD_WIDTH-1:0] dat_out_q,  dat_out_d;

  logic [PW-1:0] nr_y, nr_t, nr_u, nr_dlt, nr_p;
  logic          adv;

  assign ready_in  = rst | ~vld_out_q | ready_out;
  assign adv       = ready_in;
  assign valid_out = vld_out_q;
  assign data_out  = dat_out_q;
  assign zero_flag = zero_out_q;

  always_comb begin
    for (int i = 0; i < NST; i++) begin
      vld_d[i]  = vld_q[i];
      zero_d[i] = zero_q[i];
      xh_d[i]   = xh_q[i];
      pay_d[i]  = pay_q[i];
      aux_d[i]  = aux_q[i];
    end
    vld_out_d  = vld_out_q;
    zero_out_d = zero_out_q;
    dat_out_d  = dat_out_q;
    nr_y   = '0;
    nr_t   = '0;
    nr_u   = '0;
    nr_dlt = '0;
    nr_p   = '0;

    if (adv) begin
      // F2S
      vld_d[0]  = valid_in;
      zero_d[0] = (data_in == '0);
      xh_d[0]   = data_in >> 1;
      pay_d[0]  = (data_in == '0) ? '0 : fix_to_float(data_in);
      aux_d[0]  = '0;

      for (int i = 1; i < NST; i++) begin
        vld_d[i]  = vld_q[i-1];
        zero_d[i] = zero_q[i-1];
        xh_d[i]   = xh_q[i-1];
        aux_d[i]  = aux_q[i-1];
      end

      // HACK and S2F
      pay_d[1] = MAGIC - (pay_q[0] >> 1);
      pay_d[2] = 32'(float_to_fix(pay_q[1][30:0]));

      for (int k = 0; k < NR_ITERS; k++) begin
        // NRa: u = x_half * y^2
        nr_y = PW'(pay_q[2+2*k][WORD_WIDTH-1:0]);
        nr_t = shr_f(nr_y * nr_y);
        nr_u = shr_f(PW'(xh_q[2+2*k]) * nr_t);
        pay_d[3+2*k] = pay_q[2+2*k];
        aux_d[3+2*k] = nr_u;

        // NRb: y = y * (1.5 - u), with the factor clamped at zero
        nr_y   = PW'(pay_q[3+2*k][WORD_WIDTH-1:0]);
        nr_dlt = (aux_q[3+2*k] > ONE_P5) ? '0 : ONE_P5 - aux_q[3+2*k];
        nr_p   = shr_f(nr_y * nr_dlt);
        pay_d[4+2*k] = 32'((nr_p > WORD_MAX) ? WORD_MAX : nr_p);
      end

      // Zero operands skip the arithmetic result entirely.
      vld_out_d  = vld_q[NST-1];
      zero_out_d = zero_q[NST-1];
      dat_out_d  = zero_q[NST-1] ? '1 : pay_q[NST-1][WORD_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '{default: 1'b0};
      zero_q     <= '{default: 1'b0};
      xh_q       <= '{default: '0};
      pay_q      <= '{default: '0};
      aux_q      <= '{default: '0};
      vld_out_q  <= 1'b0;
      zero_out_q <= 1'b0;
      dat_out_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      zero_q     <= zero_d;
      xh_q       <= xh_d;
      pay_q      <= pay_d;
      aux_q      <= aux_d;
      vld_out_q  <= vld_out_d;
      zero_out_q <= zero_out_d;
      dat_out_q  <= dat_out_d;
    end
  end

endmodule

// File: tb/tb_fast_inv_sqrt_pipe.sv
// Directed bench for fast_inv_sqrt_pipe: default-parameter instance plus an NR_ITERS=0 instance
// sharing the operand inputs; expected values hand-derived from the bit-hack + NR arithmetic.
module tb_fast_inv_sqrt_pipe;
  localparam int W = 16;

`ifdef FAST_INV_SQRT_ROUND_EN
  localparam logic [W-1:0] E_10 = 16'h0010;
  localparam logic [W-1:0] E_40 = 16'h0008;
  localparam logic [W-1:0] E_01 = 16'h005C;
`else
  localparam logic [W-1:0] E_10 = 16'h000F;
  localparam logic [W-1:0] E_40 = 16'h0007;
  localparam logic [W-1:0] E_01 = 16'h005B;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         ready_out;
  logic         zero_flag;
  logic         rdy0, vld0, zf0;
  logic [W-1:0] dat0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fast_inv_sqrt_pipe dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out), .zero_flag(zero_flag)
  );

  fast_inv_sqrt_pipe #(.NR_ITERS(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy0),
    .data_out(dat0), .valid_out(vld0), .ready_out(1'b1), .zero_flag(zf0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operand; measures latency on both instances.
  task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] e,
                         input logic [W-1:0] e0, input logic ez);
    int           cnt;
    int           lat0;
    logic [W-1:0] d0;
    logic         z0;
    data_in   = x;
    valid_in  = 1'b1;
    ready_out = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    cnt  = 1;
    lat0 = -1;
    d0   = '0;
    z0   = 1'b0;
    while (cnt < 20) begin
      if (vld0 && lat0 < 0) begin
        lat0 = cnt;
        d0   = dat0;
        z0   = zf0;
      end
      if (valid_out) break;
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_lat"},   cnt,       6);
    check({tag, "_dat"},   data_out,  e);
    check({tag, "_zf"},    zero_flag, ez);
    check({tag, "_lat0"},  lat0,      4);
    check({tag, "_dat0"},  d0,        e0);
    check({tag, "_zf0"},   z0,        ez);
    @(posedge clk); #1;
    check({tag, "_drain"}, valid_out, 1'b0);
  endtask

  // Four-operand stream; optional 3-cycle output stall while the second result is presented.
  task automatic run_stream(input bit stall);
    logic [W-1:0] s  [4];
    logic [W-1:0] ex [4];
    logic         ez [4];
    int           i, nout, stall_left, first_cyc, last_cyc, gate;
    bit           acc;
    s  = '{16'h0010, 16'h0040, 16'h0000, 16'h0010};
    ex = '{E_10, E_40, 16'hFFFF, E_10};
    ez = '{1'b0, 1'b0, 1'b1, 1'b0};
    i = 0; nout = 0; stall_left = stall ? 3 : 0; first_cyc = -1; last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      gate      = (stall && i >= 2) ? i + 4 : i;
      valid_in  = (i < 4) && (cyc >= gate);
      data_in   = (i < 4) ? s[i] : '0;
      ready_out = !(stall_left > 0 && nout == 1);
      #1;
      if (!ready_out) begin
        check("stall_rdy_in", ready_in,  1'b0);
        check("stall_vld",    valid_out, 1'b1);
        check("stall_hold",   data_out,  ex[1]);
        stall_left--;
      end
      if (valid_out && ready_out) begin
        if (nout < 4) begin
          check($sformatf("%s%0d_dat", stall ? "st" : "bb", nout), data_out,  ex[nout]);
          check($sformatf("%s%0d_zf",  stall ? "st" : "bb", nout), zero_flag, ez[nout]);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nout++;
      end
      acc = valid_in && ready_in;
      @(posedge clk); #1;
      if (acc) i++;
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    check(stall ? "st_count" : "bb_count", nout, 4);
    if (!stall) check("bb_span", last_cyc - first_cyc, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_in_hi", ready_in, 1'b1);
    check("rst_rdy0",      rdy0,     1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_vld",    valid_out, 1'b0);
    check("rst_dat",    data_out,  16'h0000);
    check("rst_zf",     zero_flag, 1'b0);
    check("rst_rdy_in", ready_in,  1'b1);

    run_one("x40",   16'h0040, E_40,     16'h0007, 1'b0);
    run_one("x10",   16'h0010, E_10,     16'h000F, 1'b0);
    run_one("x00",   16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
    run_one("x01",   16'h0001, E_01,     16'h003D, 1'b0);
    run_one("xffff", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

    run_stream(1'b0);
    run_stream(1'b1);

    // Reset with three operands in flight.
    ready_out = 1'b1;
    data_in = 16'h0040; valid_in = 1'b1; @(posedge clk); #1;
    data_in = 16'h0010;                  @(posedge clk); #1;
    data_in = 16'h0000;                  @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_rdy_in", ready_in, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_vld",    valid_out, 1'b0);
    check("mid_rst_dat",    data_out,  16'h0000);
    check("mid_rst_zf",     zero_flag, 1'b0);
    check("mid_rst_rdy_in", ready_in,  1'b1);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (valid_out || vld0) seen++;
    end
    check("mid_rst_flush", seen, 0);
    run_one("post_rst", 16'h0010, E_10, 16'h000F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
